// File: rtl/udp_ctrl_pkg.sv
// Shared definitions for the UDP control-register writer and checker:
// FSM states, control-word bit layout and the word builder.
package udp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        WAIT_ACK,
        HOLDOFF
    } udp_state_e;

    localparam int unsigned CTRL_W     = 32;
    localparam int unsigned SEQ_W      = 8;
    localparam int unsigned PKTCNT_W   = 16;
    localparam int unsigned START_BIT  = 0;
    localparam int unsigned STOP_BIT   = 1;
    localparam int unsigned SEQ_LSB    = 8;
    localparam int unsigned PKTCNT_LSB = 16;

    // A stop command always carries a zero packet count.
    function automatic logic [CTRL_W-1:0] build_ctrl_word(
        input logic                stop,
        input logic [PKTCNT_W-1:0] pkt_cnt,
        input logic [SEQ_W-1:0]    seq
    );
        logic [CTRL_W-1:0] w;
        w                         = '0;
        w[START_BIT]              = ~stop;
        w[STOP_BIT]               = stop;
        w[SEQ_LSB +: SEQ_W]       = seq;
        w[PKTCNT_LSB +: PKTCNT_W] = stop ? '0 : pkt_cnt;
        return w;
    endfunction

endpackage

// File: rtl/udp_cmd_timer.sv
// Loadable saturating down-counter; expired_o is high while the count is zero.
module udp_cmd_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Flag is registered alongside the count so it always equals (cnt_q == 0).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            expired_o <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            expired_o <= (cnt_d == '0);
        end
    end

endmodule

// File: rtl/udp_start_cmd_gen.sv
// Start/stop command writer: formats a control word, strobes it out on wren,
// waits for ack with timeout/retry, then holds off before the next command.
module udp_start_cmd_gen
    import udp_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned WREN_LEN       = 2,
    parameter int unsigned ACK_TIMEOUT    = 1024,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic                  s_aclk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_stop,
    input  logic [15:0]           cmd_pkt_cnt,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  wren,
    input  logic                  ack,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [7:0]            seq_o
);

    localparam int unsigned WR_W     = (WREN_LEN > 1) ? $clog2(WREN_LEN) : 1;
    localparam int unsigned RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TMR_MAX  = (ACK_TIMEOUT > HOLDOFF_CYCLES) ? ACK_TIMEOUT : HOLDOFF_CYCLES;
    localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);
    localparam bit          SKIP_HOLD = (HOLDOFF_CYCLES == 0);

    localparam logic [TMR_W-1:0] ACK_LOAD  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = SKIP_HOLD ? '0 : TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [WR_W-1:0]  WR_LAST   = WR_W'(WREN_LEN - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRY);

    udp_state_e            state_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  wren_q;
    logic                  cmd_ready_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [7:0]            seq_q;
    logic [WR_W-1:0]       wr_cnt_q;
    logic [RTY_W-1:0]      retry_q;

    logic                  tmr_load_c;
    logic [TMR_W-1:0]      tmr_val_c;
    logic                  tmr_expired;

    // Timer is held at the ack timeout during WRITE and reloaded for holdoff on ack.
    always_comb begin
        tmr_load_c = (state_q == WRITE) || ((state_q == WAIT_ACK) && ack);
        tmr_val_c  = ack ? HOLD_LOAD : ACK_LOAD;
    end

    udp_cmd_timer #(
        .CNT_W(TMR_W)
    ) u_timer (
        .clk_i      (s_aclk),
        .rst_i      (reset),
        .load_i     (tmr_load_c),
        .load_val_i (tmr_val_c),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge s_aclk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            wren_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            seq_q       <= '0;
            wr_cnt_q    <= '0;
            retry_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        data_q      <= DATA_WIDTH'(build_ctrl_word(cmd_stop, cmd_pkt_cnt,
                                                                   seq_q + 8'd1));
                        seq_q       <= seq_q + 8'd1;
                        err_q       <= 1'b0;
                        retry_q     <= '0;
                        wr_cnt_q    <= '0;
                        wren_q      <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= WRITE;
                    end
                end
                WRITE: begin
                    if (ack) begin
                        wren_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= SKIP_HOLD ? IDLE : HOLDOFF;
                        cmd_ready_q <= SKIP_HOLD;
                        busy_q      <= !SKIP_HOLD;
                    end else if (wr_cnt_q == WR_LAST) begin
                        wren_q  <= 1'b0;
                        state_q <= WAIT_ACK;
                    end else begin
                        wr_cnt_q <= wr_cnt_q + WR_W'(1);
                    end
                end
                WAIT_ACK: begin
                    // An ack arriving with expiry takes priority over the retry.
                    if (ack) begin
                        done_q      <= 1'b1;
                        state_q     <= SKIP_HOLD ? IDLE : HOLDOFF;
                        cmd_ready_q <= SKIP_HOLD;
                        busy_q      <= !SKIP_HOLD;
                    end else if (tmr_expired) begin
                        if (retry_q < RTY_MAX) begin
                            retry_q  <= retry_q + RTY_W'(1);
                            wr_cnt_q <= '0;
                            wren_q   <= 1'b1;
                            state_q  <= WRITE;
                        end else begin
                            err_q       <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                HOLDOFF: begin
                    if (tmr_expired) begin
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    wren_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign wren      = wren_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign seq_o     = seq_q;

endmodule

// File: tb/tb_udp_start_cmd_gen.sv
// Directed bench for udp_start_cmd_gen (ACK_TIMEOUT shortened to 8 cycles).
module tb_udp_start_cmd_gen;

    localparam int unsigned DW = 32;

    logic          s_aclk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_stop;
    logic [15:0]   cmd_pkt_cnt;
    logic [DW-1:0] data;
    logic          wren;
    logic          ack;
    logic          busy;
    logic          done;
    logic          err;
    logic [7:0]    seq_o;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 s_aclk = ~s_aclk;

    udp_start_cmd_gen #(
        .DATA_WIDTH     (DW),
        .WREN_LEN       (2),
        .ACK_TIMEOUT    (8),
        .MAX_RETRY      (3),
        .HOLDOFF_CYCLES (4)
    ) dut (
        .s_aclk      (s_aclk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_stop    (cmd_stop),
        .cmd_pkt_cnt (cmd_pkt_cnt),
        .data        (data),
        .wren        (wren),
        .ack         (ack),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .seq_o       (seq_o)
    );

    function automatic logic [31:0] exp_word(input bit stop, input logic [15:0] pc,
                                             input logic [7:0] sq);
        return {(stop ? 16'h0000 : pc), sq, 6'b000000, stop, ~stop};
    endfunction

    task automatic tick();
        @(posedge s_aclk);
        #1;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Presents a command for one edge, then scrambles the fields.
    task automatic accept(input bit stop, input logic [15:0] pc);
        cmd_valid   = 1'b1;
        cmd_stop    = stop;
        cmd_pkt_cnt = pc;
        tick();
        cmd_valid   = 1'b0;
        cmd_stop    = ~stop;
        cmd_pkt_cnt = 16'hDEAD;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_stop = 1'b0; cmd_pkt_cnt = '0; ack = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL rst_ready got=%b exp=1", cmd_ready); end
        n_vec++; if (wren !== 1'b0) begin n_miss++; $display("FAIL rst_wren got=%b exp=0", wren); end
        n_vec++; if (data !== 32'h0) begin n_miss++; $display("FAIL rst_data got=%h exp=0", data); end
        n_vec++; if ({busy, done, err} !== 3'b000) begin n_miss++; $display("FAIL rst_status got=%b exp=000", {busy, done, err}); end
        n_vec++; if (seq_o !== 8'h00) begin n_miss++; $display("FAIL rst_seq got=%h exp=00", seq_o); end
    endtask

    task automatic test_start_prompt_ack();
        accept(1'b0, 16'h0010);                                 // cycle 1
        n_vec++; if (data !== 32'h0010_0101) begin n_miss++; $display("FAIL start_data got=%h exp=00100101", data); end
        n_vec++; if (wren !== 1'b1) begin n_miss++; $display("FAIL start_wren_c1 got=%b exp=1", wren); end
        n_vec++; if ({busy, cmd_ready} !== 2'b10) begin n_miss++; $display("FAIL start_busy got=%b exp=10", {busy, cmd_ready}); end
        n_vec++; if (seq_o !== 8'h01) begin n_miss++; $display("FAIL start_seq got=%h exp=01", seq_o); end
        tick();                                                 // cycle 2
        n_vec++; if (wren !== 1'b1) begin n_miss++; $display("FAIL start_wren_c2 got=%b exp=1", wren); end
        tick();                                                 // cycle 3
        n_vec++; if (wren !== 1'b0) begin n_miss++; $display("FAIL start_wren_c3 got=%b exp=0", wren); end
        tick();                                                 // cycle 4
        ack = 1'b1;
        n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL start_done_c4 got=%b exp=0", done); end
        tick();                                                 // cycle 5
        ack = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_miss++; $display("FAIL start_done_c5 got=%b exp=1", done); end
        tick();                                                 // cycle 6
        n_vec++; if (done !== 1'b0) begin n_miss++; $display("FAIL start_done_c6 got=%b exp=0", done); end
        tick(); tick();                                         // cycle 8
        n_vec++; if (cmd_ready !== 1'b0) begin n_miss++; $display("FAIL start_ready_c8 got=%b exp=0", cmd_ready); end
        tick();                                                 // cycle 9
        n_vec++; if ({cmd_ready, busy, err} !== 3'b100) begin n_miss++; $display("FAIL start_ready_c9 got=%b exp=100", {cmd_ready, busy, err}); end
        n_vec++; if (data !== 32'h0010_0101) begin n_miss++; $display("FAIL start_data_hold got=%h exp=00100101", data); end
    endtask

    task automatic test_stop();
        bit ok;
        accept(1'b1, 16'hFFFF);
        n_vec++; if (data !== 32'h0000_0202) begin n_miss++; $display("FAIL stop_data got=%h exp=00000202", data); end
        n_vec++; if (seq_o !== 8'h02) begin n_miss++; $display("FAIL stop_seq got=%h exp=02", seq_o); end
        tick(); tick();                                         // cycle 3, WAIT_ACK
        ack = 1'b1;
        tick();
        ack = 1'b0;
        n_vec++; if (done !== 1'b1) begin n_miss++; $display("FAIL stop_done got=%b exp=1", done); end
        wait_ready(20, ok);
        n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL stop_ready_timeout got=%b exp=1", ok); end
    endtask

    task automatic test_timeout_retry();
        int  bursts = 0, wcyc = 0, bad = 0, dones = 0, first_ready = 0;
        bit  prev = 1'b0;
        bit  ok;
        accept(1'b0, 16'h1234);
        for (int cyc = 1; cyc <= 41; cyc++) begin
            if (wren === 1'b1) begin
                wcyc++;
                if (!prev) bursts++;
                if (data !== 32'h1234_0301) bad++;
            end
            if (done === 1'b1) dones++;
            if (cmd_ready === 1'b1 && first_ready == 0) first_ready = cyc;
            prev = (wren === 1'b1);
            if (cyc < 41) tick();
        end
        n_vec++; if (bursts != 4) begin n_miss++; $display("FAIL to_bursts got=%0d exp=4", bursts); end
        n_vec++; if (wcyc != 8) begin n_miss++; $display("FAIL to_wren_cycles got=%0d exp=8", wcyc); end
        n_vec++; if (bad != 0) begin n_miss++; $display("FAIL to_burst_data bad=%0d exp=0", bad); end
        n_vec++; if (dones != 0) begin n_miss++; $display("FAIL to_done got=%0d exp=0", dones); end
        n_vec++; if (first_ready != 41) begin n_miss++; $display("FAIL to_ready_cycle got=%0d exp=41", first_ready); end
        n_vec++; if ({err, busy} !== 2'b10) begin n_miss++; $display("FAIL to_err got=%b exp=10", {err, busy}); end
        repeat (3) tick();
        n_vec++; if (err !== 1'b1) begin n_miss++; $display("FAIL to_err_sticky got=%b exp=1", err); end
        accept(1'b0, 16'h0001);
        n_vec++; if (err !== 1'b0) begin n_miss++; $display("FAIL to_err_clear got=%b exp=0", err); end
        n_vec++; if (seq_o !== 8'h04) begin n_miss++; $display("FAIL to_seq got=%h exp=04", seq_o); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        wait_ready(20, ok);
        n_vec++; if (ok !== 1'b1) begin n_miss++; $display("FAIL to_ready_timeout got=%b exp=1", ok); end
    endtask

    task automatic test_ack_in_write();
        int wcyc = 0, dones = 0, rdy_cyc = 0;
        accept(1'b0, 16'h0005);                                 // cycle 1
        ack = 1'b1;
        tick();                                                 // cycle 2
        ack = 1'b0;
        n_vec++; if ({wren, done} !== 2'b01) begin n_miss++; $display("FAIL aw_cut got=%b exp=01", {wren, done}); end
        n_vec++; if (data !== 32'h0005_0501) begin n_miss++; $display("FAIL aw_data got=%h exp=00050501", data); end
        for (int cyc = 3; cyc <= 22; cyc++) begin
            tick();
            if (wren === 1'b1) wcyc++;
            if (done === 1'b1) dones++;
            if (cmd_ready === 1'b1 && rdy_cyc == 0) rdy_cyc = cyc;
        end
        n_vec++; if (wcyc != 0 || dones != 0) begin n_miss++; $display("FAIL aw_extra wren=%0d done=%0d exp=0/0", wcyc, dones); end
        n_vec++; if (rdy_cyc != 6) begin n_miss++; $display("FAIL aw_ready_cycle got=%0d exp=6", rdy_cyc); end
    endtask

    task automatic test_ack_at_expiry();
        int wcyc = 0, dones = 0, errs = 0;
        accept(1'b0, 16'h0006);                                 // cycle 1
        repeat (9) tick();                                      // cycle 10, last WAIT_ACK cycle
        n_vec++; if ({wren, busy, done} !== 3'b010) begin n_miss++; $display("FAIL ae_c10 got=%b exp=010", {wren, busy, done}); end
        ack = 1'b1;
        tick();                                                 // cycle 11
        ack = 1'b0;
        n_vec++; if ({wren, done} !== 2'b01) begin n_miss++; $display("FAIL ae_c11 got=%b exp=01", {wren, done}); end
        for (int cyc = 12; cyc <= 31; cyc++) begin
            tick();
            if (wren === 1'b1) wcyc++;
            if (done === 1'b1) dones++;
            if (err === 1'b1) errs++;
        end
        n_vec++; if (wcyc != 0 || dones != 0 || errs != 0) begin n_miss++; $display("FAIL ae_extra wren=%0d done=%0d err=%0d exp=0/0/0", wcyc, dones, errs); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL ae_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_seq_wrap();
        logic [7:0]  exp_seq = 8'h06;
        logic [15:0] pc;
        bit          stop, ok, dut_ff = 1'b0, dut_wrap = 1'b0;
        for (int i = 0; i < 256; i++) begin
            exp_seq = exp_seq + 8'd1;
            stop    = i[0];
            pc      = 16'(i * 3 + 1);
            accept(stop, pc);
            n_vec++; if (seq_o !== exp_seq) begin n_miss++; $display("FAIL wrap_seq[%0d] got=%h exp=%h", i, seq_o, exp_seq); end
            n_vec++; if (data !== exp_word(stop, pc, exp_seq)) begin n_miss++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, data, exp_word(stop, pc, exp_seq)); end
            if (seq_o === 8'hFF) dut_ff = 1'b1;
            if (dut_ff && seq_o === 8'h00) dut_wrap = 1'b1;
            ack = 1'b1;
            tick();
            ack = 1'b0;
            wait_ready(20, ok);
            if (!ok) begin
                n_vec++; n_miss++;
                $display("FAIL wrap_ready_timeout[%0d] got=0 exp=1", i);
            end
        end
        n_vec++; if (dut_ff !== 1'b1) begin n_miss++; $display("FAIL wrap_reach_ff got=%b exp=1", dut_ff); end
        n_vec++; if (dut_wrap !== 1'b1) begin n_miss++; $display("FAIL wrap_to_00 got=%b exp=1", dut_wrap); end
    endtask

    task automatic test_reset_mid_wait();
        int wcyc = 0, dones = 0, errs = 0;
        accept(1'b0, 16'h00AA);
        repeat (3) tick();                                      // cycle 4, WAIT_ACK
        n_vec++; if ({busy, wren} !== 2'b10) begin n_miss++; $display("FAIL rm_pre got=%b exp=10", {busy, wren}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (wren !== 1'b0) begin n_miss++; $display("FAIL rm_wren got=%b exp=0", wren); end
        n_vec++; if (data !== 32'h0) begin n_miss++; $display("FAIL rm_data got=%h exp=0", data); end
        n_vec++; if (seq_o !== 8'h00) begin n_miss++; $display("FAIL rm_seq got=%h exp=00", seq_o); end
        n_vec++; if ({busy, cmd_ready} !== 2'b01) begin n_miss++; $display("FAIL rm_busy got=%b exp=01", {busy, cmd_ready}); end
        for (int cyc = 0; cyc < 25; cyc++) begin
            ack = (cyc == 3);
            tick();
            if (wren === 1'b1) wcyc++;
            if (done === 1'b1) dones++;
            if (err === 1'b1) errs++;
        end
        ack = 1'b0;
        n_vec++; if (wcyc != 0 || dones != 0 || errs != 0) begin n_miss++; $display("FAIL rm_after wren=%0d done=%0d err=%0d exp=0/0/0", wcyc, dones, errs); end
        n_vec++; if (cmd_ready !== 1'b1) begin n_miss++; $display("FAIL rm_ready got=%b exp=1", cmd_ready); end
    endtask

    initial begin
        test_reset();
        test_start_prompt_ack();
        test_stop();
        test_timeout_retry();
        test_ack_in_write();
        test_ack_at_expiry();
        test_seq_wrap();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired vectors=%0d miscompares=%0d", n_vec, n_miss);
        $fatal(1);
    end

endmodule

// File: doc/udp_start_cmd_gen.md
Name: udp_start_cmd_gen

Overview:
Writer-side counterpart of the UDP control-register checker. It accepts start/stop commands from local control logic and formats each one into a control word. It drives that word onto the data/wren register-write interface and waits for the far side to acknowledge. Commands that are not acknowledged time out and are retried, with busy/done/err status returned to the requester. Sits in the s_aclk domain directly upstream of the control-register checker.

Parameters:
DATA_WIDTH, 32, width of register write data; must be >= 32.
WREN_LEN, 2, cycles wren is held high per write attempt (>=1; stretches the pulse for a slower consumer clock).
ACK_TIMEOUT, 1024, cycles to wait for ack after the write pulse ends (>=1).
MAX_RETRY, 3, write re-attempts after the first timeout before flagging an error (0 = no retry).
HOLDOFF_CYCLES, 4, idle cycles after a successful ack before the next command is accepted (0 allowed).

Ports:
s_aclk  input  1  single clock for the whole block
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command
cmd_stop  input  1  0 = start UDP, 1 = stop UDP
cmd_pkt_cnt  input  16  packet count for a start (ignored for a stop, encoded as 0)
data  output  DATA_WIDTH  control word to the register interface
wren  output  1  register write strobe
ack  input  1  single-cycle acknowledge from the far side
busy  output  1  command in flight
done  output  1  one-cycle pulse on acknowledged command
err  output  1  sticky; set on retry exhaustion, cleared when the next command is accepted
seq_o  output  8  sequence id of the current or last command

Behaviour:
- Reset (sync, active-high): state=IDLE; data=0, wren=0, done=0, err=0, busy=0, seq_o=0, cmd_ready=1 on the first cycle after reset deasserts. Reset mid-operation aborts with no further wren.
- Control word: data[0]=~cmd_stop; data[1]=cmd_stop; data[7:2]=0; data[15:8]=seq; data[31:16]=cmd_pkt_cnt (forced to 0 when cmd_stop=1); bits above 31 = 0.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. cmd_ready=1 only in IDLE. Command fields are latched at acceptance and need not remain stable afterwards.
- On acceptance: seq increments (mod 256; 255 wraps to 0), err clears, the retry count clears, and the state moves to WRITE.
- States:
  IDLE: cmd_ready=1, busy=0.
  WRITE: wren=1 for exactly WREN_LEN cycles, then WAIT_ACK.
  WAIT_ACK: wren=0; a timer counts from 0.
  ack seen -> done=1 for one cycle, then HOLDOFF.
  Timer reaches ACK_TIMEOUT with retries < MAX_RETRY -> retry count +1, back to WRITE with the same data and seq.
  Retries exhausted -> err=1, then IDLE.
  HOLDOFF: count HOLDOFF_CYCLES, then IDLE; if HOLDOFF_CYCLES=0, go straight to IDLE.
- busy=1 in WRITE, WAIT_ACK and HOLDOFF.
- Latency: with acceptance at edge N, data is valid and wren high from cycle N+1 through N+WREN_LEN. data holds the word from N+1 until the next acceptance (a retry does not change it).
- ack in WRITE counts as acknowledgement: wren is cut at the next edge, and done pulses the cycle after the ack. ack in IDLE or HOLDOFF is ignored.
- ack on the same cycle the timer expires: the ack wins and no retry occurs.
- Timer width is clog2(ACK_TIMEOUT+1); the retry counter width is clog2(MAX_RETRY+1). Neither wraps; both saturate at their limit.

Decomposition:
- Package udp_ctrl_pkg holds:
  - the state enum (IDLE, WRITE, WAIT_ACK, HOLDOFF);
  - control-word bit-position localparams (START_BIT=0, STOP_BIT=1, SEQ_LSB=8, PKTCNT_LSB=16);
  - a function building the word from stop/pkt_cnt/seq.
- The checker on the receive side imports the same package.
- One natural sub-module, udp_cmd_timer: a loadable down-counter with an expiry flag, used for both the ack timeout and the holdoff.

Test Plan:
- Start, prompt ack: cmd_stop=0, cmd_pkt_cnt=0x0010 accepted at edge 0; ack at cycle 4. Expected: data=0x0010_0101, wren high cycles 1-2, done at cycle 5, cmd_ready back after 4 holdoff cycles, err=0.
- Stop command: cmd_stop=1, cmd_pkt_cnt=0xFFFF. Expected: data=0x0000_0202 (second command, seq=2), pkt_cnt forced to 0.
- Timeout with retry: ACK_TIMEOUT=8, no ack. Expected: 4 wren bursts with identical data, then err=1, busy=0, cmd_ready=1, done never pulses. A following accepted command clears err.
- Ack during WRITE, and ack coincident with timer expiry. Expected in both cases: exactly one done pulse and no extra wren burst.
- Sequence wrap: issue 256 acked commands. Expected: seq_o reaches 0xFF, then 0x00, and data[15:8] tracks seq_o.
- Reset mid-WAIT_ACK. Expected: next cycle wren=0, data=0, seq_o=0, busy=0, and no done/err pulse afterwards.
